// File: rtl/hs_mem_pkg.sv
// Shared memory-block types and helpers for the hs_mem family.
// Provides the read-during-write policy enum and the byte-lane merge.
package hs_mem_pkg;

  typedef enum logic {
    RDW_OLD_DATA = 1'b0,
    RDW_NEW_DATA = 1'b1
  } rdw_mode_e;

  localparam int unsigned HS_MEM_MAX_RD_LATENCY = 3;
  localparam int unsigned HS_MEM_MAX_DW = 256;
  localparam int unsigned HS_MEM_MAX_BYTES = 32;

  typedef logic [HS_MEM_MAX_DW-1:0] hs_word_t;
  typedef logic [HS_MEM_MAX_BYTES-1:0] hs_ben_t;

  // Callers zero-extend into the max-width types and truncate the result.
  function automatic hs_word_t byte_merge(
    input hs_word_t    old_w,
    input hs_word_t    new_w,
    input hs_ben_t     ben,
    input int unsigned bw
  );
    hs_word_t m;
    logic [4:0] lane;
    m = old_w;
    for (int unsigned i = 0; i < HS_MEM_MAX_DW; i++) begin
      lane = 5'((i / bw) % HS_MEM_MAX_BYTES);
      if (ben[lane]) m[i] = new_w[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/hs_mem_rd_pipe.sv
// Resettable data+valid shift pipeline behind the array read stage.
// STAGES=0 degenerates to wires; data only advances with its valid.
module hs_mem_rd_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned STAGES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_v,
  input  logic [DW-1:0] in_d,
  output logic          out_v,
  output logic [DW-1:0] out_d
);

  if (STAGES == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n};
    assign out_v = in_v;
    assign out_d = in_d;
  end else begin : g_regs
    logic [STAGES-1:0] v;
    logic [DW-1:0]     d [STAGES];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v <= '0;
        for (int i = 0; i < int'(STAGES); i++) d[i] <= '0;
      end else begin
        v[0] <= in_v;
        if (in_v) d[0] <= in_d;
        for (int i = 1; i < int'(STAGES); i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end

    assign out_v = v[STAGES-1];
    assign out_d = d[STAGES-1];
  end

endmodule

// File: rtl/hs_mem_sdpram_pipe.sv
// 1W/1R simple dual-port RAM: byte enables, 1..3 cycle read, RDW policy.
// Optional power-up clear FSM: HS_MEM_SDPRAM_PIPE_CLEAR_EN.
module hs_mem_sdpram_pipe
  import hs_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter rdw_mode_e   RDW_MODE   = RDW_OLD_DATA,
  localparam int unsigned NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NUM_BYTES-1:0]  wben,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  init_busy
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  if (RD_LATENCY < 1 || RD_LATENCY > HS_MEM_MAX_RD_LATENCY) begin : g_bad_lat
    $error("hs_mem_sdpram_pipe: RD_LATENCY must be 1..3");
  end
  if (BYTE_WIDTH == 0 || DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("hs_mem_sdpram_pipe: DATA_WIDTH not a multiple of BYTE_WIDTH");
  end
  if (DATA_WIDTH > HS_MEM_MAX_DW || NUM_BYTES > HS_MEM_MAX_BYTES) begin : g_bad_dw
    $error("hs_mem_sdpram_pipe: DATA_WIDTH too wide");
  end
  if (DATA_DEPTH < 2 || DATA_DEPTH > 1048576) begin : g_bad_depth
    $error("hs_mem_sdpram_pipe: DATA_DEPTH must be 2..1048576");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  busy;
  logic                  waddr_ok;
  logic                  raddr_ok;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [NUM_BYTES-1:0]  wbe;
  logic                  rd_go;
  logic                  collide;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_v;
  logic [DATA_WIDTH-1:0] s1_d;

`ifdef HS_MEM_SDPRAM_PIPE_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) state <= ST_RUN;
      else clr_addr <= clr_addr + 1'b1;
    end
  end

  assign busy = (state == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  assign init_busy = busy;
  assign waddr_ok  = (32'(waddr) < DATA_DEPTH);
  assign raddr_ok  = (32'(raddr) < DATA_DEPTH);

  // Single write port, borrowed by the clear sequencer while busy.
  always_comb begin
    we  = wen & waddr_ok & ~busy;
    wa  = waddr;
    wd  = wdata;
    wbe = wben;
`ifdef HS_MEM_SDPRAM_PIPE_CLEAR_EN
    if (busy) begin
      we  = 1'b1;
      wa  = clr_addr;
      wd  = '0;
      wbe = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        if (wbe[i]) mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_go    = ren & ~busy;
  assign collide  = wen & waddr_ok & ~busy & (waddr == raddr);
  assign old_word = mem[raddr];
  assign merged   = DATA_WIDTH'(byte_merge(hs_word_t'(old_word),
                                           hs_word_t'(wdata),
                                           hs_ben_t'(wben),
                                           BYTE_WIDTH));

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if (collide && RDW_MODE == RDW_NEW_DATA) rd_word = merged;
      else rd_word = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= rd_go;
      if (rd_go) s1_d <= rd_word;
    end
  end

  hs_mem_rd_pipe #(
    .DW     (DATA_WIDTH),
    .STAGES (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (s1_v),
    .in_d  (s1_d),
    .out_v (rvalid),
    .out_d (rdata)
  );

endmodule

// File: tb/tb_hs_mem_sdpram_pipe.sv
// Scoreboard bench: three RAM configs share one stimulus stream.
// a: lat2/old/16, b: lat3/new/16, c: lat1/old/12 (non-pow2 depth).
module tb_hs_mem_sdpram_pipe;
  import hs_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wben  = '0;
  logic        wen   = 1'b0;
  logic [3:0]  raddr = '0;
  logic        ren   = 1'b0;

  logic [2:0][31:0] rd;
  logic [2:0]       rv;
  logic [2:0]       busy;

  hs_mem_sdpram_pipe #(
    .DATA_DEPTH(16), .RD_LATENCY(2), .RDW_MODE(RDW_OLD_DATA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wben(wben),
    .wen(wen), .raddr(raddr), .ren(ren), .rdata(rd[0]), .rvalid(rv[0]),
    .init_busy(busy[0])
  );

  hs_mem_sdpram_pipe #(
    .DATA_DEPTH(16), .RD_LATENCY(3), .RDW_MODE(RDW_NEW_DATA)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wben(wben),
    .wen(wen), .raddr(raddr), .ren(ren), .rdata(rd[1]), .rvalid(rv[1]),
    .init_busy(busy[1])
  );

  hs_mem_sdpram_pipe #(
    .DATA_DEPTH(12), .RD_LATENCY(1), .RDW_MODE(RDW_OLD_DATA)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .wben(wben),
    .wen(wen), .raddr(raddr), .ren(ren), .rdata(rd[2]), .rvalid(rv[2]),
    .init_busy(busy[2])
  );

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_smp = 1'b0;
  logic [31:0] last [3];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst_n;
  end

  function automatic int lat_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qflush(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC0, b, 8'h5A, ~b};
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)",
               nm, i, act, exp, cyc);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    if (!rst_smp) begin
      chk("rst_rvalid", i, {31'b0, rv[i]}, 32'd0);
      chk("rst_rdata", i, rd[i], 32'd0);
      last[i] = '0;
      qflush(i);
    end else if (rv[i]) begin
      if (qsize(i) == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_rvalid dut%0d: got rdata %h, expected no read (cycle %0d)",
                 i, rd[i], cyc);
      end else begin
        e = qpop(i);
        chk("rdata", i, rd[i], e.d);
        chk("latency", i, 32'(cyc), 32'(e.c));
      end
      last[i] = rd[i];
    end else begin
      chk("rdata_hold", i, rd[i], last[i]);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) mon(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input logic r, input logic [3:0] ra,
                    input logic [31:0] ea, input logic [31:0] eb,
                    input logic [31:0] ec);
    wen   = w;
    waddr = wa;
    wdata = wd;
    wben  = be;
    ren   = r;
    raddr = ra;
    if (r) begin
      qpush(0, '{d: ea, c: cyc + lat_of(0)});
      qpush(1, '{d: eb, c: cyc + lat_of(1)});
      qpush(2, '{d: ec, c: cyc + lat_of(2)});
    end
    step();
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    op(1'b1, a, d, be, 1'b0, 4'd0, '0, '0, '0);
  endtask

  task automatic rdx(input logic [3:0] a, input logic [31:0] ea,
                     input logic [31:0] eb, input logic [31:0] ec);
    op(1'b0, 4'd0, '0, 4'd0, 1'b1, a, ea, eb, ec);
  endtask

  task automatic release_reset();
`ifdef HS_MEM_SDPRAM_PIPE_CLEAR_EN
    int cnt [3];
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    rst_n = 1'b1;
    raddr = 4'd0;
    ren   = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (busy[i]) cnt[i]++;
      ren = &busy;
      if (busy == 3'b000) break;
    end
    ren = 1'b0;
    chk("busy_cycles", 0, 32'(cnt[0]), 32'd16);
    chk("busy_cycles", 1, 32'(cnt[1]), 32'd16);
    chk("busy_cycles", 2, 32'(cnt[2]), 32'd12);
`else
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("init_busy", i, {31'b0, busy[i]}, 32'd0);
`endif
    step();
  endtask

  initial begin
    logic [31:0] post;
    logic [31:0] pc;
    repeat (3) step();
    release_reset();

    // latency and full-word write
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rdx(4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

    // byte-lane write keeps disabled lanes
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rdx(4'd5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    // same-cycle collision, then read-after-write
    wr(4'd7, 32'h0, 4'hF);
    op(1'b1, 4'd7, 32'h55, 4'hF, 1'b1, 4'd7, 32'h0, 32'h55, 32'h0);
    rdx(4'd7, 32'h55, 32'h55, 32'h55);

    // partial-lane collision merge
    wr(4'd8, 32'hA5A5A5A5, 4'hF);
    op(1'b1, 4'd8, 32'h12345678, 4'b0011, 1'b1, 4'd8,
       32'hA5A5A5A5, 32'hA5A55678, 32'hA5A5A5A5);
    rdx(4'd8, 32'hA5A55678, 32'hA5A55678, 32'hA5A55678);

    // out-of-range address on the 12-deep instance
    wr(4'd13, 32'hCAFEF00D, 4'hF);
    rdx(4'd13, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);

    // streaming reads, one per cycle
    for (int i = 0; i < 16; i++) wr(4'(i), pat(i), 4'hF);
    for (int i = 0; i < 16; i++) begin
      pc = (i < 12) ? pat(i) : 32'h0;
      rdx(4'(i), pat(i), pat(i), pc);
    end
    repeat (5) step();

    // reset with reads in flight
    rdx(4'd1, pat(1), pat(1), pat(1));
    rdx(4'd2, pat(2), pat(2), pat(2));
    rst_n = 1'b0;
    repeat (3) step();
    release_reset();
    repeat (6) step();

`ifdef HS_MEM_SDPRAM_PIPE_CLEAR_EN
    post = 32'h0;
`else
    post = pat(0);
`endif
    rdx(4'd0, post, post, post);
    wr(4'd9, 32'h0BADF00D, 4'b1000);
    wr(4'd9, 32'h13579BDF, 4'b0111);
`ifdef HS_MEM_SDPRAM_PIPE_CLEAR_EN
    post = 32'h0B579BDF;
`else
    post = 32'h0B579BDF;
`endif
    rdx(4'd9, post, post, post);

    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qsize(i) != 0) begin
        errs++;
        $display("FAIL missing_rvalid dut%0d: %0d reads outstanding, expected 0",
                 i, qsize(i));
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected finish");
    $fatal(1);
  end

endmodule
